// File: rtl/rom_uart_loader.sv
// rom_uart_loader: boot loader that receives an instruction image over an
// 8N1 UART line, writes it word by word into the instruction ROM write port
// and holds the CPU in reset until the image has been accepted.
//
// Frame: 4-byte LE word count N, N x 4-byte LE words, then an optional
// checksum byte (8-bit sum of all length and data bytes).
// Optional feature macro: LOADER_CHECKSUM_EN (checksum byte and CSUM state).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   uart_rx    serial input, idle high, asynchronous to clk
//   rom_we     one-cycle ROM write strobe
//   rom_waddr  ROM word address
//   rom_wdata  ROM write data
//   cpu_rst_n  CPU reset, released once the image is accepted
//   busy       load in progress (first start bit until DONE/ERR)
//   load_done  sticky, image accepted
//   load_err   sticky, image rejected
module rom_uart_loader #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_e;

    typedef enum logic [2:0] {
        LD_LEN  = 3'd0,
        LD_DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        LD_CSUM = 3'd2,
`endif
        LD_DONE = 3'd3,
        LD_ERR  = 3'd4
    } ld_e;

    // Receiver state
    logic             rx_s1_q, rx_s2_q, rx_p_q;
    rx_e              rx_st_q, rx_st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             rx_valid_q, rx_valid_d;
    logic             start_ok;
    logic             ferr;

    // Loader state
    ld_e               ld_q, ld_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       acc_q, acc_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic [31:0]     asm_w;
    logic [ADDR_W:0] next_widx;
    ld_e             body_end;

    assign asm_w     = {sh_q, acc_q};
    assign next_widx = widx_q + 1'b1;

`ifdef LOADER_CHECKSUM_EN
    assign body_end = LD_CSUM;
`else
    assign body_end = LD_DONE;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_p_q     <= 1'b1;
            rx_st_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            rx_valid_q <= 1'b0;
            ld_q       <= LD_LEN;
            bcnt_q     <= '0;
            acc_q      <= '0;
            n_q        <= '0;
            widx_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_p_q     <= rx_s2_q;
            rx_st_q    <= rx_st_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rx_valid_q <= rx_valid_d;
            ld_q       <= ld_d;
            bcnt_q     <= bcnt_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            widx_q     <= widx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // UART receiver. Returns to idle at mid stop bit so that back-to-back
    // frames are caught; sh_q holds the byte while rx_valid_q is high.
    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_valid_d = 1'b0;
        start_ok   = 1'b0;
        ferr       = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s2_q && rx_p_q) begin
                    rx_st_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_s2_q) begin
                        // line back high: glitch, not a start bit
                        rx_st_d = RX_IDLE;
                    end else begin
                        rx_st_d  = RX_DATA;
                        bit_d    = '0;
                        start_ok = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    rx_st_d = RX_IDLE;
                    if (rx_s2_q) begin
                        rx_valid_d = 1'b1;
                    end else begin
                        ferr = 1'b1;
                    end
                end
            end
            default: begin
                rx_st_d = RX_IDLE;
            end
        endcase
    end

    // Loader FSM. Framing errors act straight off the stop-bit sample so
    // load_err rises the cycle after it.
    always_comb begin
        ld_d    = ld_q;
        bcnt_d  = bcnt_q;
        acc_d   = acc_q;
        n_d     = n_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (ld_q)
            LD_LEN: begin
                if (ferr) begin
                    ld_d = LD_ERR;
                end else if (rx_valid_q) begin
                    acc_d  = asm_w[31:8];
                    bcnt_d = bcnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + sh_q;
`endif
                    if (bcnt_q == 2'd3) begin
                        n_d = asm_w[ADDR_W:0];
                        if ({1'b0, asm_w} > MAX_WORDS) begin
                            ld_d = LD_ERR;
                        end else if (asm_w == '0) begin
                            ld_d = body_end;
                        end else begin
                            ld_d = LD_DATA;
                        end
                    end
                end
            end
            LD_DATA: begin
                if (ferr) begin
                    ld_d = LD_ERR;
                end else if (rx_valid_q) begin
                    acc_d  = asm_w[31:8];
                    bcnt_d = bcnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + sh_q;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = widx_q[ADDR_W-1:0];
                        wdata_d = asm_w;
                        widx_d  = next_widx;
                        if (next_widx == n_q) begin
                            ld_d = body_end;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (ferr) begin
                    ld_d = LD_ERR;
                end else if (rx_valid_q) begin
                    ld_d = (sh_q == sum_q) ? LD_DONE : LD_ERR;
                end
            end
`endif
            LD_DONE: begin
                ld_d = LD_DONE;
            end
            LD_ERR: begin
                ld_d = LD_ERR;
            end
            default: begin
                ld_d = LD_ERR;
            end
        endcase
        if (ld_d == LD_DONE || ld_d == LD_ERR) begin
            busy_d = 1'b0;
        end else if (start_ok) begin
            busy_d = 1'b1;
        end
    end

    assign rom_we    = we_q;
    assign rom_waddr = waddr_q;
    assign rom_wdata = wdata_q;
    assign busy      = busy_q;
    assign load_done = (ld_q == LD_DONE);
    assign cpu_rst_n = (ld_q == LD_DONE);
    assign load_err  = (ld_q == LD_ERR);

endmodule

// File: tb/tb_rom_uart_loader.sv
// tb_rom_uart_loader: directed bench for rom_uart_loader with a fast
// baud setting (16 clocks per bit); covers both checksum configurations.
module tb_rom_uart_loader;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        rom_we;
    logic [11:0] rom_waddr;
    logic [31:0] rom_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] wr_a [64];
    logic [31:0] wr_d [64];
    int          wr_n = 0;
    int          base;

    logic [7:0] frm [$];

    rom_uart_loader #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000),
        .ADDR_W  (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rom_we   (rom_we),
        .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata),
        .cpu_rst_n(cpu_rst_n),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_we) begin
            wr_a[wr_n % 64] <= rom_waddr;
            wr_d[wr_n % 64] <= rom_wdata;
            wr_n            <= wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop,
                             input bit probe);
        uart_rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(DIV);
        end
        uart_rx = stop;
        idle(4);
        if (probe) check("done_before_stop_mid", load_done, 0);
        idle(DIV - 4);
        uart_rx = 1'b1;
    endtask

    task automatic send_frm(input int cnt, input bit probe_last);
        for (int i = 0; i < cnt; i++) begin
            send_byte(frm[i], 1'b1, probe_last && (i == cnt - 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_rst_vals(input string p);
        check({p, "_we"},    rom_we, 0);
        check({p, "_waddr"}, rom_waddr, 0);
        check({p, "_wdata"}, rom_wdata, 0);
        check({p, "_cpurst"}, cpu_rst_n, 0);
        check({p, "_busy"},  busy, 0);
        check({p, "_done"},  load_done, 0);
        check({p, "_err"},   load_err, 0);
    endtask

    task automatic nominal_frame();
        frm = '{8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        frm.push_back(8'hB8);
`endif
    endtask

    initial begin
        // reset state
        idle(3);
        do_reset();
        check_rst_vals("rst");

        // nominal load
        nominal_frame();
        base = wr_n;
        send_frm(frm.size(), 1'b1);
        idle(4);
        check("nom_wr_cnt", wr_n - base, 2);
        check("nom_wr0_a", wr_a[base % 64], 0);
        check("nom_wr0_d", wr_d[base % 64], 32'h0000_0013);
        check("nom_wr1_a", wr_a[(base + 1) % 64], 1);
        check("nom_wr1_d", wr_d[(base + 1) % 64], 32'h0010_0093);
        check("nom_done", load_done, 1);
        check("nom_cpurst", cpu_rst_n, 1);
        check("nom_err", load_err, 0);
        check("nom_busy", busy, 0);

        // traffic after DONE is ignored
        base = wr_n;
        send_byte(8'h5A, 1'b1, 1'b0);
        idle(4);
        check("post_done", load_done, 1);
        check("post_wr_cnt", wr_n - base, 0);
        check("post_busy", busy, 0);

`ifdef LOADER_CHECKSUM_EN
        // bad checksum
        do_reset();
        nominal_frame();
        frm[12] = 8'hB9;
        base = wr_n;
        send_frm(frm.size(), 1'b0);
        idle(4);
        check("bad_wr_cnt", wr_n - base, 2);
        check("bad_wr1_d", wr_d[(base + 1) % 64], 32'h0010_0093);
        check("bad_err", load_err, 1);
        check("bad_cpurst", cpu_rst_n, 0);
        check("bad_done", load_done, 0);
`endif

        // oversize length
        do_reset();
        frm = '{8'h01, 8'h10, 8'h00, 8'h00};
        base = wr_n;
        send_frm(4, 1'b0);
        idle(4);
        check("big_err", load_err, 1);
        check("big_wr_cnt", wr_n - base, 0);
        check("big_busy", busy, 0);
        check("big_cpurst", cpu_rst_n, 0);

        // glitch then framing error
        do_reset();
        idle(5);
        uart_rx = 1'b0;
        idle(5);
        uart_rx = 1'b1;
        idle(10);
        check("glitch_busy", busy, 0);
        idle(30);
        check("glitch_busy2", busy, 0);
        check("glitch_err", load_err, 0);
        send_byte(8'h55, 1'b0, 1'b0);
        idle(4);
        check("ferr_err", load_err, 1);
        check("ferr_busy", busy, 0);
        check("ferr_cpurst", cpu_rst_n, 0);

        // reset mid-load, then replay
        do_reset();
        nominal_frame();
        send_frm(6, 1'b0);
        idle(2);
        check("mid_busy", busy, 1);
        do_reset();
        check_rst_vals("mid");
        idle(10);
        base = wr_n;
        send_frm(frm.size(), 1'b0);
        idle(4);
        check("replay_wr_cnt", wr_n - base, 2);
        check("replay_wr0_d", wr_d[base % 64], 32'h0000_0013);
        check("replay_wr1_a", wr_a[(base + 1) % 64], 1);
        check("replay_done", load_done, 1);
        check("replay_cpurst", cpu_rst_n, 1);

        // single-word image
        do_reset();
        frm = '{8'h01, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        frm.push_back(8'h70);
`endif
        base = wr_n;
        send_frm(frm.size(), 1'b1);
        idle(2);
        check("one_wr_cnt", wr_n - base, 1);
        check("one_wr0_a", wr_a[base % 64], 0);
        check("one_wr0_d", wr_d[base % 64], 32'h0000_006F);
        check("one_done", load_done, 1);

        // empty image
        do_reset();
        frm = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        frm.push_back(8'h00);
`endif
        base = wr_n;
        send_frm(frm.size(), 1'b1);
        idle(2);
        check("zero_wr_cnt", wr_n - base, 0);
        check("zero_done", load_done, 1);
        check("zero_err", load_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_uart_loader.md
# rom_uart_loader

Boot-time program loader sitting directly upstream of the instruction ROM in `riscv_cpu_soc`. It receives an instruction image over a UART serial line, writes it word by word into the ROM's write port, and holds the CPU in reset until the image has been loaded and accepted. It replaces simulation-only ROM preloading on hardware, so the same rv32ui test images can be executed on silicon or FPGA.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: UART bit rate; bit period `BAUD_DIV = CLK_FREQ/BAUD` cycles, integer-truncated.
- `ADDR_W`, 12: ROM word-address width; capacity `MAX_WORDS = 2**ADDR_W`.

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `uart_rx` input 1: serial data, 8N1, idle high, asynchronous to `clk`.
- `rom_we` output 1: one-cycle ROM write strobe.
- `rom_waddr` output ADDR_W: ROM word address.
- `rom_wdata` output 32: ROM write data.
- `cpu_rst_n` output 1: active-low reset to `riscv_cpu`; low until load is accepted.
- `busy` output 1: high from the first start bit until DONE or ERR.
- `load_done` output 1: sticky; image accepted.
- `load_err` output 1: sticky; load rejected.

## Operation
- `uart_rx` passes through a 2-FF synchronizer. The receiver waits for a falling edge, then re-samples at `BAUD_DIV/2`. If the line is high, the start bit is a glitch and is discarded. Otherwise the 8 data bits are sampled LSB first at each subsequent `BAUD_DIV`, then the stop bit. A stop bit of 0 is a framing error.
- Frame format:
  - 4-byte little-endian word count N.
  - N × 4-byte little-endian words.
  - 1 checksum byte, present only when checksum is enabled (see Configuration).
- FSM states and transitions:
  - LEN: collect 4 bytes. If N > MAX_WORDS, go to ERR. If N = 0, go to CSUM (or DONE without checksum). Otherwise go to DATA.
  - DATA: assemble each word. On its 4th byte, pulse `rom_we` with `rom_waddr` equal to the word index (starting at 0). After word N-1, go to CSUM, or DONE without checksum.
  - CSUM: receive 1 byte. If it equals the 8-bit modulo-256 sum of all length and data bytes, go to DONE; otherwise go to ERR.
  - DONE: set `load_done`=1 and `cpu_rst_n`=1. Ignore further RX traffic.
  - ERR: set `load_err`=1; `cpu_rst_n` stays 0. Ignore further RX traffic.
- A framing error in any receiving state goes to ERR. DONE and ERR are left only by reset.
- Words already written before an error remain in ROM. The CPU never runs on a rejected image.
- The word index is ADDR_W+1 bits wide internally, so N = MAX_WORDS is legal and does not wrap.

## Timing
- Reset values: `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0, `cpu_rst_n`=0, `busy`=0, `load_done`=0, `load_err`=0; FSM in LEN.
- Reset mid-frame aborts the frame and returns to the reset state on the next edge. The next load starts from LEN.
- A byte is valid 1 cycle after the stop-bit sample (mid stop bit).
- `rom_we` rises the cycle after the 4th byte of a word is valid. `rom_waddr` and `rom_wdata` are stable in that same cycle and hold until the next write.
- `load_done`/`cpu_rst_n` rise the cycle after the final byte is valid: the checksum byte, or the last data byte without checksum. For N=0 without checksum, they rise the cycle after the 4th length byte.
- `load_err` rises the cycle after the offending byte or stop-bit sample. `busy` falls in that same cycle.
- The receiver returns to idle at mid stop bit, so back-to-back bytes with no idle gap are accepted.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CSUM state exists and the checksum byte is required. Mismatch causes ERR.
- Not defined: no checksum byte and no CSUM state. The image is accepted after the last data word.

## Test plan
All byte values are hex; checksum enabled unless noted.
- Nominal load: send `02 00 00 00 13 00 00 00 93 00 10 00 B8` at CLK_FREQ=50 MHz, BAUD=115200. Required: writes (0, 0x00000013) then (1, 0x00100093); `load_done`=1; `cpu_rst_n`=1; `load_err`=0.
- Bad checksum: same frame with last byte `B9`. Required: both writes occur, `load_err`=1, `cpu_rst_n` stays 0.
- Oversize: length bytes `01 10 00 00` (N=0x1001 > 4096). Required: `load_err`=1 after the 4th byte; no `rom_we`.
- Framing error and glitch:
  - Drive `uart_rx` low for 100 cycles (< 217) during idle. Required: ignored, `busy` stays 0.
  - Then send a byte with stop bit 0. Required: `load_err`=1.
- Reset mid-load: assert `rst`=0 for 1 cycle after the 6th byte. Required: all outputs return to reset values. Replaying the nominal frame then yields `load_done`=1.
- Without `LOADER_CHECKSUM_EN`: send `01 00 00 00 6F 00 00 00`. Required: write (0, 0x0000006F); `load_done`=1 one cycle after the last byte is valid.
